// File: rtl/alu_pkg.sv
// Shared types for the ALU reservation station.
// Holds op codes, widths and the per-entry record.
package alu_pkg;

   localparam int DATA_W = 64;
   localparam int TAG_W  = 5;

   typedef enum logic [2:0] {
      PASS_B = 3'b000,
      ADD    = 3'b010,
      SUB    = 3'b011,
      AND    = 3'b100,
      OR     = 3'b101,
      XOR    = 3'b110
   } alu_op_t;

   typedef struct packed {
      logic              valid;
      alu_op_t           cntrl;
      logic [TAG_W-1:0]  dest_tag;
      logic              a_rdy;
      logic [TAG_W-1:0]  a_tag;
      logic [DATA_W-1:0] a_val;
      logic              b_rdy;
      logic [TAG_W-1:0]  b_tag;
      logic [DATA_W-1:0] b_val;
   } rs_entry_t;

endpackage

// File: rtl/rs_entry.sv
// One reservation-station slot: holds an op and snoops the CDB.
// Ports: clk/reset_n/flush_i, alloc_i+disp_i load, cdb_*_i snoop, clr_i frees, ent_o/rdy_o state.
module rs_entry
   import alu_pkg::*;
(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              flush_i,
   input  logic              alloc_i,
   input  rs_entry_t         disp_i,
   input  logic              cdb_valid_i,
   input  logic [TAG_W-1:0]  cdb_tag_i,
   input  logic [DATA_W-1:0] cdb_val_i,
   input  logic              clr_i,
   output rs_entry_t         ent_o,
   output logic              rdy_o
);

   rs_entry_t e_q, e_d;
   rs_entry_t load;
   logic      hit_a, hit_b;

   assign hit_a = e_q.valid & ~e_q.a_rdy
                & cdb_valid_i & (cdb_tag_i == e_q.a_tag);
   assign hit_b = e_q.valid & ~e_q.b_rdy
                & cdb_valid_i & (cdb_tag_i == e_q.b_tag);

   // Dispatch bypass: an operand arriving on the CDB in the
   // dispatch cycle is captured straight into the new entry.
   always_comb begin
      load = disp_i;
      load.valid = 1'b1;
      if (!disp_i.a_rdy && cdb_valid_i
          && cdb_tag_i == disp_i.a_tag) begin
         load.a_rdy = 1'b1;
         load.a_val = cdb_val_i;
      end
      if (!disp_i.b_rdy && cdb_valid_i
          && cdb_tag_i == disp_i.b_tag) begin
         load.b_rdy = 1'b1;
         load.b_val = cdb_val_i;
      end
   end

   always_comb begin
      e_d = e_q;
      if (hit_a) begin
         e_d.a_rdy = 1'b1;
         e_d.a_val = cdb_val_i;
      end
      if (hit_b) begin
         e_d.b_rdy = 1'b1;
         e_d.b_val = cdb_val_i;
      end
      if (clr_i)
         e_d.valid = 1'b0;
      if (alloc_i)
         e_d = load;
      if (flush_i)
         e_d.valid = 1'b0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         e_q <= '0;
      else
         e_q <= e_d;
   end

   assign ent_o = e_q;
   assign rdy_o = e_q.valid & e_q.a_rdy & e_q.b_rdy;

endmodule

// File: rtl/alu_reservation_station.sv
// Reservation station feeding the 64-bit integer ALU.
// Ports: dispatch (disp_*), CDB snoop (cdb_*), issue (iss_*), flush, count.
module alu_reservation_station
   import alu_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int TAG_W  = alu_pkg::TAG_W,
   parameter int DATA_W = alu_pkg::DATA_W
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     flush,
   input  logic                     disp_valid,
   output logic                     disp_ready,
   input  logic [2:0]               disp_cntrl,
   input  logic [TAG_W-1:0]         disp_dest_tag,
   input  logic                     disp_a_rdy,
   input  logic [DATA_W-1:0]        disp_a_val,
   input  logic [TAG_W-1:0]         disp_a_tag,
   input  logic                     disp_b_rdy,
   input  logic [DATA_W-1:0]        disp_b_val,
   input  logic [TAG_W-1:0]         disp_b_tag,
   input  logic                     cdb_valid,
   input  logic [TAG_W-1:0]         cdb_tag,
   input  logic [DATA_W-1:0]        cdb_val,
   output logic                     iss_valid,
   input  logic                     iss_ready,
   output logic [DATA_W-1:0]        iss_A,
   output logic [DATA_W-1:0]        iss_B,
   output logic [2:0]               iss_cntrl,
   output logic [TAG_W-1:0]         iss_dest_tag,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   rs_entry_t             ents [DEPTH];
   logic [DEPTH-1:0]      vld, rdy;
   logic [DEPTH-1:0]      alloc_oh, clr_oh;
   logic [IDX_W-1:0]      sel;
   logic                  disp_fire, iss_fire;
   rs_entry_t             disp_e;
   logic [CNT_W-1:0]      count_q, count_d;

   always_comb begin
      disp_e          = '0;
      disp_e.cntrl    = alu_op_t'(disp_cntrl);
      disp_e.dest_tag = disp_dest_tag;
      disp_e.a_rdy    = disp_a_rdy;
      disp_e.a_tag    = disp_a_tag;
      disp_e.a_val    = disp_a_val;
      disp_e.b_rdy    = disp_b_rdy;
      disp_e.b_tag    = disp_b_tag;
      disp_e.b_val    = disp_b_val;
   end

   // Full-ness comes from registered valids only, so a slot
   // freed by this cycle's issue is not reused until next cycle.
   assign disp_ready = ~&vld;
   assign disp_fire  = disp_valid & disp_ready & ~flush;

   always_comb begin
      alloc_oh = '0;
      for (int i = DEPTH - 1; i >= 0; i--)
         if (!vld[i]) alloc_oh = DEPTH'(1) << i;
   end

   always_comb begin
      sel = '0;
      for (int i = DEPTH - 1; i >= 0; i--)
         if (rdy[i]) sel = IDX_W'(i);
   end

   assign iss_valid = |rdy;
   assign iss_fire  = iss_valid & iss_ready;

   always_comb begin
      clr_oh = '0;
      if (iss_fire) clr_oh[sel] = 1'b1;
   end

   for (genvar g = 0; g < DEPTH; g++) begin : g_ent
      rs_entry u_ent (
         .clk         (clk),
         .reset_n     (reset_n),
         .flush_i     (flush),
         .alloc_i     (alloc_oh[g] & disp_fire),
         .disp_i      (disp_e),
         .cdb_valid_i (cdb_valid),
         .cdb_tag_i   (cdb_tag),
         .cdb_val_i   (cdb_val),
         .clr_i       (clr_oh[g]),
         .ent_o       (ents[g]),
         .rdy_o       (rdy[g])
      );
      assign vld[g] = ents[g].valid;
   end

   always_comb begin
      iss_A        = '0;
      iss_B        = '0;
      iss_cntrl    = '0;
      iss_dest_tag = '0;
      if (iss_valid) begin
         iss_A        = ents[sel].a_val;
         iss_B        = ents[sel].b_val;
         iss_cntrl    = ents[sel].cntrl;
         iss_dest_tag = ents[sel].dest_tag;
      end
   end

   always_comb begin
      count_d = count_q + CNT_W'(disp_fire) - CNT_W'(iss_fire);
      if (flush) count_d = '0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         count_q <= '0;
      else
         count_q <= count_d;
   end

   assign count = count_q;

endmodule

// File: tb/tb_alu_reservation_station.sv
// Directed bench for alu_reservation_station.
// Drives dispatch/CDB/issue vectors and checks hand-computed outputs.
module tb_alu_reservation_station;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        flush;
   logic        disp_valid;
   logic        disp_ready;
   logic [2:0]  disp_cntrl;
   logic [4:0]  disp_dest_tag;
   logic        disp_a_rdy;
   logic [63:0] disp_a_val;
   logic [4:0]  disp_a_tag;
   logic        disp_b_rdy;
   logic [63:0] disp_b_val;
   logic [4:0]  disp_b_tag;
   logic        cdb_valid;
   logic [4:0]  cdb_tag;
   logic [63:0] cdb_val;
   logic        iss_valid;
   logic        iss_ready;
   logic [63:0] iss_A;
   logic [63:0] iss_B;
   logic [2:0]  iss_cntrl;
   logic [4:0]  iss_dest_tag;
   logic [2:0]  count;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   alu_reservation_station dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .flush         (flush),
      .disp_valid    (disp_valid),
      .disp_ready    (disp_ready),
      .disp_cntrl    (disp_cntrl),
      .disp_dest_tag (disp_dest_tag),
      .disp_a_rdy    (disp_a_rdy),
      .disp_a_val    (disp_a_val),
      .disp_a_tag    (disp_a_tag),
      .disp_b_rdy    (disp_b_rdy),
      .disp_b_val    (disp_b_val),
      .disp_b_tag    (disp_b_tag),
      .cdb_valid     (cdb_valid),
      .cdb_tag       (cdb_tag),
      .cdb_val       (cdb_val),
      .iss_valid     (iss_valid),
      .iss_ready     (iss_ready),
      .iss_A         (iss_A),
      .iss_B         (iss_B),
      .iss_cntrl     (iss_cntrl),
      .iss_dest_tag  (iss_dest_tag),
      .count         (count)
   );

   task automatic chk(input string tag,
                      input logic [63:0] got,
                      input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic disp(input logic [2:0] op,
                       input logic [4:0] dt,
                       input logic ar, input logic [63:0] av,
                       input logic [4:0] at,
                       input logic br, input logic [63:0] bv,
                       input logic [4:0] bt);
      disp_valid    = 1'b1;
      disp_cntrl    = op;
      disp_dest_tag = dt;
      disp_a_rdy    = ar;
      disp_a_val    = av;
      disp_a_tag    = at;
      disp_b_rdy    = br;
      disp_b_val    = bv;
      disp_b_tag    = bt;
   endtask

   task automatic cdb(input logic [4:0] t, input logic [63:0] v);
      cdb_valid = 1'b1;
      cdb_tag   = t;
      cdb_val   = v;
   endtask

   initial begin
      reset_n = 1'b0;
      flush = 0; disp_valid = 0; disp_cntrl = 0;
      disp_dest_tag = 0; disp_a_rdy = 0; disp_a_val = 0;
      disp_a_tag = 0; disp_b_rdy = 0; disp_b_val = 0;
      disp_b_tag = 0; cdb_valid = 0; cdb_tag = 0;
      cdb_val = 0; iss_ready = 0;
      #2;
      chk("rst_dr", disp_ready, 1);
      chk("rst_iv", iss_valid, 0);
      chk("rst_cnt", count, 0);
      chk("rst_A", iss_A, 0);
      #10 reset_n = 1'b1;
      step();

      // T1 ready dispatch
      disp(3'b010, 5'd3, 1, 64'd5, 0, 1, 64'd7, 0);
      step();
      disp_valid = 0;
      chk("t1_iv", iss_valid, 1);
      chk("t1_A", iss_A, 5);
      chk("t1_B", iss_B, 7);
      chk("t1_op", iss_cntrl, 3'b010);
      chk("t1_tag", iss_dest_tag, 3);
      chk("t1_cnt", count, 1);
      iss_ready = 1;
      step();
      iss_ready = 0;
      chk("t1_cnt0", count, 0);
      chk("t1_iv0", iss_valid, 0);

      // T2 wakeup
      disp(3'b011, 5'd4, 1, 64'h10, 0, 0, 64'h0, 5'd9);
      step();
      disp_valid = 0;
      chk("t2_wait0", iss_valid, 0);
      cdb(5'd8, 64'h77);
      step();
      chk("t2_miss", iss_valid, 0);
      cdb(5'd9, 64'h4);
      step();
      cdb_valid = 0;
      chk("t2_iv", iss_valid, 1);
      chk("t2_A", iss_A, 64'h10);
      chk("t2_B", iss_B, 64'h4);
      chk("t2_op", iss_cntrl, 3'b011);
      iss_ready = 1;
      step();
      iss_ready = 0;
      chk("t2_cnt", count, 0);

      // T3 dispatch bypass
      disp(3'b000, 5'd6, 1, 64'h1, 0, 0, 64'h0, 5'd2);
      cdb(5'd2, '1);
      step();
      disp_valid = 0;
      cdb_valid = 0;
      chk("t3_iv", iss_valid, 1);
      chk("t3_B", iss_B, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("t3_tag", iss_dest_tag, 6);
      iss_ready = 1;
      step();
      iss_ready = 0;

      // T4 full and backpressure
      for (int i = 0; i < 4; i++) begin
         disp(3'b100, 5'(10 + i), 1, 64'(i), 0,
              0, 64'h0, 5'(20 + i));
         step();
      end
      disp_valid = 0;
      chk("t4_dr", disp_ready, 0);
      chk("t4_cnt", count, 4);
      disp(3'b101, 5'd15, 1, 0, 0, 1, 0, 0);
      step();
      disp_valid = 0;
      chk("t4_cnt5", count, 4);
      cdb(5'd22, 64'h22);
      step();
      cdb_valid = 0;
      chk("t4_iv", iss_valid, 1);
      chk("t4_tag", iss_dest_tag, 12);
      chk("t4_A", iss_A, 2);
      chk("t4_drx", disp_ready, 0);
      iss_ready = 1;
      step();
      iss_ready = 0;
      chk("t4_dr1", disp_ready, 1);
      chk("t4_cnt3", count, 3);
      flush = 1;
      step();
      flush = 0;
      chk("t4_fl", count, 0);

      // T5 selection order, shared tag on entries 1 and 3
      disp(3'b110, 5'd10, 1, 64'h0, 0, 0, 0, 5'd20);
      step();
      disp(3'b110, 5'd11, 1, 64'h1, 0, 0, 0, 5'd7);
      step();
      disp(3'b110, 5'd12, 1, 64'h2, 0, 0, 0, 5'd22);
      step();
      disp(3'b110, 5'd13, 0, 64'h0, 5'd7, 0, 0, 5'd7);
      step();
      disp_valid = 0;
      chk("t5_iv0", iss_valid, 0);
      cdb(5'd7, 64'h99);
      step();
      cdb_valid = 0;
      chk("t5_tag1", iss_dest_tag, 11);
      chk("t5_B1", iss_B, 64'h99);
      iss_ready = 1;
      step();
      chk("t5_tag3", iss_dest_tag, 13);
      chk("t5_A3", iss_A, 64'h99);
      chk("t5_B3", iss_B, 64'h99);
      step();
      iss_ready = 0;
      chk("t5_iv1", iss_valid, 0);
      chk("t5_cnt", count, 2);

      // T6 flush with 3 occupied and a dispatch pending
      disp(3'b010, 5'd14, 1, 64'h5, 0, 1, 64'h6, 0);
      step();
      disp_valid = 0;
      chk("t6_cnt3", count, 3);
      chk("t6_iv", iss_valid, 1);
      disp(3'b010, 5'd15, 1, 64'h5, 0, 1, 64'h6, 0);
      flush = 1;
      step();
      flush = 0;
      disp_valid = 0;
      chk("t6_cnt0", count, 0);
      chk("t6_iv0", iss_valid, 0);
      chk("t6_dr", disp_ready, 1);
      step();
      chk("t6_drop", iss_valid, 0);

      // T6 async reset mid-cycle
      disp(3'b101, 5'd1, 1, 64'hAB, 0, 1, 64'hCD, 0);
      step();
      disp_valid = 0;
      chk("t6r_iv", iss_valid, 1);
      #3 reset_n = 1'b0;
      #1;
      chk("t6r_iv0", iss_valid, 0);
      chk("t6r_cnt", count, 0);
      chk("t6r_A", iss_A, 0);
      chk("t6r_dr", disp_ready, 1);
      #2 reset_n = 1'b1;
      step();
      chk("t6r_post", iss_valid, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
